hw_tr_table: RTL and testbench

HW_TR_TABLE -- requirements
Module: hw_tr_table

---
 rtl/hw_tr_table.sv | 168 ++++++++++++++++
 tb/tb_hw_tr_table.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hw_tr_table.sv
// rtl/hw_tr_table.sv - expected-transaction table with sequential search, match/remove and dump.
// Optional statistics counters are built when HW_TR_TABLE_STATS_EN is defined.
module hw_tr_table #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ADD_VLD,
  input  logic [DATA_WIDTH-1:0] ADD_DATA,
  output logic                  ADD_RDY,
  input  logic                  CHK_VLD,
  input  logic [DATA_WIDTH-1:0] CHK_DATA,
  output logic                  CHK_RDY,
  output logic                  RES_VLD,
  output logic                  RES_MATCH,
  output logic [IDX_W-1:0]      RES_INDEX,
  input  logic                  DUMP_REQ,
  output logic                  DUMP_VLD,
  output logic [DATA_WIDTH-1:0] DUMP_DATA,
  output logic [IDX_W-1:0]      DUMP_INDEX,
  output logic                  DUMP_DONE,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [IDX_W:0]        COUNT,
  output logic [31:0]           CNT_ADDED,
  output logic [31:0]           CNT_MATCHED,
  output logic [31:0]           CNT_MISSED
);

  typedef enum logic [1:0] {IDLE, SEARCH, DUMP} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      occ, dump_pend, add_mask;
  logic [IDX_W-1:0]      sidx, free_idx, dump_idx;
  logic [DATA_WIDTH-1:0] chk_q;
  logic [IDX_W:0]        count;
  logic                  res_vld_q, res_match_q;
  logic [IDX_W-1:0]      res_index_q;
  logic                  full, add_fire, chk_fire, dump_fire;
  logic                  hit, last, dump_any, is_idle;

  assign full      = (count == (IDX_W+1)'(DEPTH));
  assign is_idle   = (state == IDLE) && !RESET;
  assign add_fire  = ADD_VLD && is_idle && !full;
  assign chk_fire  = CHK_VLD && is_idle;
  assign dump_fire = DUMP_REQ && !CHK_VLD && is_idle;
  assign hit       = occ[sidx] && (mem[sidx] == chk_q);
  assign last      = (sidx == IDX_W'(DEPTH-1));
  assign dump_any  = |dump_pend;
  assign add_mask  = add_fire ? (DEPTH'(1) << free_idx) : '0;

  // Lowest free slot for inserts, lowest still-pending slot for the dump walk.
  always_comb begin
    free_idx = '0;
    dump_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!occ[i]) free_idx = IDX_W'(i);
      if (dump_pend[i]) dump_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (chk_fire) state_next = SEARCH;
               else if (dump_fire) state_next = DUMP;
      SEARCH:  if (hit || last) state_next = IDLE;
      DUMP:    if (!dump_any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ADD_RDY    = is_idle && !full;
    CHK_RDY    = is_idle;
    DUMP_VLD   = (state == DUMP) && dump_any && !RESET;
    DUMP_DONE  = (state == DUMP) && !dump_any && !RESET;
    DUMP_DATA  = DUMP_VLD ? mem[dump_idx] : '0;
    DUMP_INDEX = DUMP_VLD ? dump_idx : '0;
  end

  always_ff @(posedge CLK) begin
    if (add_fire) mem[free_idx] <= ADD_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      occ         <= '0;
      dump_pend   <= '0;
      count       <= '0;
      sidx        <= '0;
      chk_q       <= '0;
      res_vld_q   <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
    end else begin
      res_vld_q   <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      case (state)
        IDLE: begin
          occ <= occ | add_mask;
          if (add_fire) count <= count + 1'b1;
          if (chk_fire) begin
            chk_q <= CHK_DATA;
            sidx  <= '0;
          end
          if (dump_fire) dump_pend <= occ | add_mask;
        end
        SEARCH: begin
          if (hit) begin
            occ[sidx]   <= 1'b0;
            count       <= count - 1'b1;
            res_vld_q   <= 1'b1;
            res_match_q <= 1'b1;
            res_index_q <= sidx;
          end else if (last) begin
            res_vld_q   <= 1'b1;
          end else begin
            sidx <= sidx + 1'b1;
          end
        end
        DUMP: if (dump_any) dump_pend[dump_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign RES_VLD   = res_vld_q && !RESET;
  assign RES_MATCH = res_match_q && !RESET;
  assign RES_INDEX = RESET ? '0 : res_index_q;
  assign COUNT     = RESET ? '0 : count;
  assign EMPTY     = RESET || (count == '0);
  assign FULL      = !RESET && full;

`ifdef HW_TR_TABLE_STATS_EN
  logic [31:0] cnt_added, cnt_matched, cnt_missed;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_added   <= '0;
      cnt_matched <= '0;
      cnt_missed  <= '0;
    end else begin
      if (add_fire) cnt_added <= cnt_added + 1'b1;
      if (state == SEARCH && hit) cnt_matched <= cnt_matched + 1'b1;
      if (state == SEARCH && !hit && last) cnt_missed <= cnt_missed + 1'b1;
    end
  end

  assign CNT_ADDED   = RESET ? '0 : cnt_added;
  assign CNT_MATCHED = RESET ? '0 : cnt_matched;
  assign CNT_MISSED  = RESET ? '0 : cnt_missed;
`else
  assign CNT_ADDED   = '0;
  assign CNT_MATCHED = '0;
  assign CNT_MISSED  = '0;
`endif

endmodule

// File: tb/tb_hw_tr_table.sv
// tb/tb_hw_tr_table.sv - directed self-checking bench for hw_tr_table (DEPTH=16, DATA_WIDTH=64).
module tb_hw_tr_table;

`ifdef HW_TR_TABLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, ADD_VLD, CHK_VLD, DUMP_REQ;
  logic [63:0] ADD_DATA, CHK_DATA, DUMP_DATA;
  logic        ADD_RDY, CHK_RDY, RES_VLD, RES_MATCH, DUMP_VLD, DUMP_DONE, EMPTY, FULL;
  logic [3:0]  RES_INDEX, DUMP_INDEX;
  logic [4:0]  COUNT;
  logic [31:0] CNT_ADDED, CNT_MATCHED, CNT_MISSED;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  hw_tr_table #(.DATA_WIDTH(64), .DEPTH(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .ADD_VLD(ADD_VLD), .ADD_DATA(ADD_DATA), .ADD_RDY(ADD_RDY),
    .CHK_VLD(CHK_VLD), .CHK_DATA(CHK_DATA), .CHK_RDY(CHK_RDY),
    .RES_VLD(RES_VLD), .RES_MATCH(RES_MATCH), .RES_INDEX(RES_INDEX),
    .DUMP_REQ(DUMP_REQ), .DUMP_VLD(DUMP_VLD), .DUMP_DATA(DUMP_DATA),
    .DUMP_INDEX(DUMP_INDEX), .DUMP_DONE(DUMP_DONE),
    .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
    .CNT_ADDED(CNT_ADDED), .CNT_MATCHED(CNT_MATCHED), .CNT_MISSED(CNT_MISSED)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; ADD_VLD = 1'b0; CHK_VLD = 1'b0; DUMP_REQ = 1'b0;
    ADD_DATA = '0; CHK_DATA = '0;
    step(); step();
    RESET = 1'b0;
    step();
  endtask

  task automatic add(input logic [63:0] d);
    ADD_VLD = 1'b1; ADD_DATA = d;
    step();
    ADD_VLD = 1'b0;
  endtask

  // Leaves the bench in the cycle RES_VLD was seen; cyc counts cycles from acceptance.
  task automatic run_check(input logic [63:0] d, output int cyc, output logic m, output logic [3:0] idx);
    CHK_VLD = 1'b1; CHK_DATA = d;
    step();
    CHK_VLD = 1'b0;
    cyc = 1;
    while (!RES_VLD && cyc < 40) begin
      step();
      cyc++;
    end
    m = RES_MATCH;
    idx = RES_INDEX;
  endtask

  task automatic test_reset();
    RESET = 1'b1; ADD_VLD = 1'b0; CHK_VLD = 1'b0; DUMP_REQ = 1'b0;
    ADD_DATA = '0; CHK_DATA = '0;
    step(); step();
    n_checks++; if (COUNT !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", COUNT); end
    n_checks++; if ({EMPTY, FULL} !== 2'b10) begin n_fail++; $display("FAIL reset_empty_full got %b want 10", {EMPTY, FULL}); end
    n_checks++; if ({ADD_RDY, CHK_RDY} !== 2'b00) begin n_fail++; $display("FAIL reset_rdy got %b want 00", {ADD_RDY, CHK_RDY}); end
    n_checks++; if ({RES_VLD, RES_MATCH, RES_INDEX} !== 6'd0) begin n_fail++; $display("FAIL reset_res got %b want 0", {RES_VLD, RES_MATCH, RES_INDEX}); end
    n_checks++; if ({DUMP_VLD, DUMP_DONE, DUMP_INDEX, DUMP_DATA} !== 70'd0) begin n_fail++; $display("FAIL reset_dump got %h want 0", {DUMP_VLD, DUMP_DONE, DUMP_INDEX, DUMP_DATA}); end
    n_checks++; if ({CNT_ADDED, CNT_MATCHED, CNT_MISSED} !== 96'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", {CNT_ADDED, CNT_MATCHED, CNT_MISSED}); end
    RESET = 1'b0;
    step();
    n_checks++; if ({ADD_RDY, CHK_RDY} !== 2'b11) begin n_fail++; $display("FAIL post_reset_rdy got %b want 11", {ADD_RDY, CHK_RDY}); end
  endtask

  task automatic test_match();
    int cyc; logic m; logic [3:0] idx;
    do_reset();
    add(64'hA); add(64'hB); add(64'hC);
    n_checks++; if (COUNT !== 5'd3) begin n_fail++; $display("FAIL match_count_pre got %0d want 3", COUNT); end
    run_check(64'hB, cyc, m, idx);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL match_latency got %0d want 3", cyc); end
    n_checks++; if ({m, idx} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL match_result got %b/%0d want 1/1", m, idx); end
    n_checks++; if (COUNT !== 5'd2) begin n_fail++; $display("FAIL match_count got %0d want 2", COUNT); end
    n_checks++; if (CNT_ADDED !== (STATS ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL match_cnt_added got %0d want %0d", CNT_ADDED, STATS ? 3 : 0); end
    step();
    n_checks++; if ({RES_VLD, CHK_RDY} !== 2'b01) begin n_fail++; $display("FAIL match_res_pulse got %b want 01", {RES_VLD, CHK_RDY}); end
    n_checks++; if (CNT_MATCHED !== (STATS ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL match_cnt_matched got %0d want %0d", CNT_MATCHED, STATS ? 1 : 0); end
  endtask

  task automatic test_miss();
    int cyc; logic m; logic [3:0] idx;
    do_reset();
    run_check(64'h5, cyc, m, idx);
    n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL miss_latency got %0d want 17", cyc); end
    n_checks++; if ({m, idx} !== 5'd0) begin n_fail++; $display("FAIL miss_result got %b/%0d want 0/0", m, idx); end
    step();
    n_checks++; if (COUNT !== 5'd0) begin n_fail++; $display("FAIL miss_count got %0d want 0", COUNT); end
    n_checks++; if (CNT_MISSED !== (STATS ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL miss_cnt_missed got %0d want %0d", CNT_MISSED, STATS ? 1 : 0); end
  endtask

  task automatic test_full();
    int cyc; logic m; logic [3:0] idx;
    do_reset();
    for (int i = 0; i < 16; i++) add(64'h100 + 64'(i));
    n_checks++; if ({FULL, ADD_RDY, COUNT} !== {1'b1, 1'b0, 5'd16}) begin n_fail++; $display("FAIL full_state got %b/%b/%0d want 1/0/16", FULL, ADD_RDY, COUNT); end
    add(64'hDEAD);
    n_checks++; if (COUNT !== 5'd16) begin n_fail++; $display("FAIL full_ignored_add got %0d want 16", COUNT); end
    run_check(64'h104, cyc, m, idx);
    n_checks++; if ({cyc == 6, m, idx} !== {1'b1, 1'b1, 4'd4}) begin n_fail++; $display("FAIL full_match4 got cyc %0d m %b idx %0d want 6/1/4", cyc, m, idx); end
    step();
    n_checks++; if ({FULL, ADD_RDY, COUNT} !== {1'b0, 1'b1, 5'd15}) begin n_fail++; $display("FAIL full_after_match got %b/%b/%0d want 0/1/15", FULL, ADD_RDY, COUNT); end
    add(64'h999);
    run_check(64'h999, cyc, m, idx);
    n_checks++; if ({cyc == 6, m, idx} !== {1'b1, 1'b1, 4'd4}) begin n_fail++; $display("FAIL full_reuse_slot got cyc %0d m %b idx %0d want 6/1/4", cyc, m, idx); end
    step();
    run_check(64'hDEAD, cyc, m, idx);
    n_checks++; if ({cyc == 17, m} !== 2'b10) begin n_fail++; $display("FAIL full_17th_absent got cyc %0d m %b want 17/0", cyc, m); end
  endtask

  task automatic test_same_cycle();
    int cyc;
    do_reset();
    ADD_VLD = 1'b1; ADD_DATA = 64'h7; CHK_VLD = 1'b1; CHK_DATA = 64'h7;
    step();
    ADD_VLD = 1'b0; CHK_VLD = 1'b0;
    cyc = 1;
    while (!RES_VLD && cyc < 40) begin step(); cyc++; end
    n_checks++; if ({cyc == 2, RES_MATCH, RES_INDEX} !== {1'b1, 1'b1, 4'd0}) begin n_fail++; $display("FAIL same_cycle_res got cyc %0d m %b idx %0d want 2/1/0", cyc, RES_MATCH, RES_INDEX); end
    step();
    n_checks++; if ({EMPTY, COUNT} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL same_cycle_empty got %b/%0d want 1/0", EMPTY, COUNT); end
  endtask

  task automatic test_dump();
    int cyc, nv, nd, done_cyc, cc; logic m; logic [3:0] idx;
    logic [3:0] got_idx [3];
    logic [63:0] got_dat [3];
    logic [3:0] exp_idx [3];
    logic [63:0] exp_dat [3];
    logic [3:0] rm [7];
    exp_idx = '{4'd0, 4'd3, 4'd9};
    exp_dat = '{64'h10, 64'h13, 64'h19};
    rm = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    do_reset();
    // empty-table dump finishes in the first cycle after acceptance
    DUMP_REQ = 1'b1; step(); DUMP_REQ = 1'b0;
    n_checks++; if ({DUMP_VLD, DUMP_DONE} !== 2'b01) begin n_fail++; $display("FAIL dump_empty got %b want 01", {DUMP_VLD, DUMP_DONE}); end
    step();
    for (int i = 0; i < 10; i++) add(64'h10 + 64'(i));
    for (int i = 0; i < 7; i++) begin
      run_check(64'h10 + 64'(rm[i]), cc, m, idx);
      step();
    end
    n_checks++; if (COUNT !== 5'd3) begin n_fail++; $display("FAIL dump_setup_count got %0d want 3", COUNT); end
    DUMP_REQ = 1'b1; step(); DUMP_REQ = 1'b0;
    nv = 0; nd = 0; done_cyc = 0;
    for (cyc = 1; cyc < 30; cyc++) begin
      if (DUMP_VLD && nv < 3) begin got_idx[nv] = DUMP_INDEX; got_dat[nv] = DUMP_DATA; end
      if (DUMP_VLD) nv++;
      if (DUMP_DONE) begin nd++; done_cyc = cyc; break; end
      step();
    end
    n_checks++; if ({nv, nd, done_cyc} !== {32'd3, 32'd1, 32'd4}) begin n_fail++; $display("FAIL dump_shape got vld %0d done %0d at %0d want 3/1/4", nv, nd, done_cyc); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (nv < 3 || got_idx[i] !== exp_idx[i] || got_dat[i] !== exp_dat[i]) begin
        n_fail++; $display("FAIL dump_entry%0d got idx %0d data %h want idx %0d data %h", i, got_idx[i], got_dat[i], exp_idx[i], exp_dat[i]);
      end
    end
    step();
    n_checks++; if ({DUMP_DONE, CHK_RDY, COUNT} !== {1'b0, 1'b1, 5'd3}) begin n_fail++; $display("FAIL dump_after got %b/%b/%0d want 0/1/3", DUMP_DONE, CHK_RDY, COUNT); end
    // check wins over a simultaneous dump request
    DUMP_REQ = 1'b1;
    run_check(64'h13, cyc, m, idx);
    DUMP_REQ = 1'b0;
    n_checks++; if ({cyc == 5, m, idx, DUMP_VLD} !== {1'b1, 1'b1, 4'd3, 1'b0}) begin n_fail++; $display("FAIL chk_priority got cyc %0d m %b idx %0d dv %b want 5/1/3/0", cyc, m, idx, DUMP_VLD); end
  endtask

  task automatic test_reset_abort();
    int seen;
    do_reset();
    add(64'h1);
    CHK_VLD = 1'b1; CHK_DATA = 64'h5;
    step();
    CHK_VLD = 1'b0;
    for (int c = 1; c < 6; c++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
    n_checks++; if ({RES_VLD, EMPTY, CHK_RDY} !== 3'b011) begin n_fail++; $display("FAIL abort_first_cycle got %b want 011", {RES_VLD, EMPTY, CHK_RDY}); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (RES_VLD) seen++;
      step();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_res got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_miss();
    test_full();
    test_same_cycle();
    test_dump();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
